// File: rtl/keypad_ascii_queue.sv
// Keypad front end: synchronises and debounces the press strobe, maps the key index to ASCII
// and queues the bytes in a first-word-fall-through FIFO drained over valid/ready.
module keypad_ascii_queue #(
    parameter int unsigned KEY_W           = 4,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned START_PULSE     = 4,
    parameter int unsigned NONE_CODE       = 11
) (
    input  logic                         FPGA_CLK1_50,
    input  logic                         reset_n,
    input  logic [KEY_W-1:0]             num,
    input  logic                         PB_state,
    input  logic                         clr_ovf,
    output logic [7:0]                   data,
    output logic                         valid,
    input  logic                         ready,
    output logic                         start,
    output logic [7:0]                   LED,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = $clog2(DEPTH+1);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RemW = $clog2(START_PULSE+1);
    localparam logic [CntW-1:0] DebMax   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [OccW-1:0] OccFull  = OccW'(DEPTH);
    localparam logic [RemW-1:0] RemStart = RemW'(START_PULSE - 1);

    typedef enum logic [1:0] {StIdle, StDebPrs, StHeld, StDebRel} state_e;

    state_e            state_q;
    logic [CntW-1:0]   deb_cnt_q;
    logic              pb_meta_q, pb_s_q;
    logic              push_q;
    logic [7:0]        push_byte_q;
    logic [7:0]        mem_q [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [OccW-1:0]   count_q, count_d;
    logic [7:0]        led_q;
    logic              start_q;
    logic [RemW-1:0]   start_rem_q;
    logic              overflow_q;

    logic [7:0]        ascii;
    logic              ascii_ok;
    logic              pop, push_ok, drop;

    always_comb begin
        ascii    = 8'h00;
        ascii_ok = 1'b1;
        unique0 case (num[3:0])
            4'd10:   ascii = 8'h2A;
            4'd11:   ascii_ok = 1'b0;
            4'd12:   ascii = 8'h23;
            4'd13:   ascii = 8'h41;
            4'd14:   ascii = 8'h42;
            4'd15:   ascii = 8'h43;
            default: ascii = 8'h30 + {4'h0, num[3:0]};
        endcase
        if (32'(num) > 32'd15 || 32'(num) == NONE_CODE) begin
            ascii_ok = 1'b0;
        end
    end

    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            pb_meta_q   <= 1'b0;
            pb_s_q      <= 1'b0;
            state_q     <= StIdle;
            deb_cnt_q   <= '0;
            push_q      <= 1'b0;
            push_byte_q <= 8'h00;
        end else begin
            pb_meta_q <= PB_state;
            pb_s_q    <= pb_meta_q;
            push_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    deb_cnt_q <= '0;
                    if (pb_s_q) state_q <= StDebPrs;
                end
                StDebPrs: begin
                    if (!pb_s_q) begin
                        state_q <= StIdle;
                    end else if (deb_cnt_q == DebMax) begin
                        // Press accepted: capture the key now, push lands next cycle
                        state_q     <= StHeld;
                        push_q      <= ascii_ok;
                        push_byte_q <= ascii;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + CntW'(1);
                    end
                end
                StHeld: begin
                    deb_cnt_q <= '0;
                    if (!pb_s_q) state_q <= StDebRel;
                end
                StDebRel: begin
                    if (pb_s_q) begin
                        state_q <= StHeld;
                    end else if (deb_cnt_q == DebMax) begin
                        state_q <= StIdle;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign valid   = (count_q != '0);
    assign data    = valid ? mem_q[rd_ptr_q] : 8'h00;
    assign pop     = valid && ready;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign push_ok = push_q && ((count_q != OccFull) || pop);
    assign drop    = push_q && (count_q == OccFull) && !pop;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) count_d = count_q + OccW'(1);
        if (!push_ok && pop) count_d = count_q - OccW'(1);
    end

    always_ff @(posedge FPGA_CLK1_50) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_byte_q;
    end

    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            led_q       <= 8'h00;
            start_q     <= 1'b0;
            start_rem_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (push_ok) begin
                led_q       <= push_byte_q;
                start_q     <= 1'b1;
                start_rem_q <= RemStart;
            end else if (start_rem_q != '0) begin
                start_rem_q <= start_rem_q - RemW'(1);
            end else begin
                start_q <= 1'b0;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign start    = start_q;
    assign LED      = led_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_ascii_queue.sv
// Scoreboard bench for keypad_ascii_queue: expected bytes are queued on key stimulus and
// compared against the FIFO head whenever the DUT hands a byte over.
module tb_keypad_ascii_queue;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] num = 4'd0;
    logic       PB_state = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       start;
    logic [7:0] LED;
    logic [2:0] count;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int start_hi = 0;
    logic [7:0] exp_q [$];

    keypad_ascii_queue #(
        .KEY_W(4), .DEPTH(4), .DEBOUNCE_CYCLES(4), .START_PULSE(4), .NONE_CODE(11)
    ) dut (
        .FPGA_CLK1_50(clk), .reset_n(reset_n), .num(num), .PB_state(PB_state),
        .clr_ovf(clr_ovf), .data(data), .valid(valid), .ready(ready), .start(start),
        .LED(LED), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshake must deliver the oldest expected byte
    always @(negedge clk) begin
        logic [7:0] e;
        if (start) start_hi++;
        if (reset_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_byte", 32'(data), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_data", 32'(data), 32'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k, input logic [7:0] b, input bit exp_push);
        num = k;
        PB_state = 1'b1;
        if (exp_push) exp_q.push_back(b);
        tick(20);
        PB_state = 1'b0;
        tick(12);
    endtask

    task automatic drain();
        int n = 0;
        ready = 1'b1;
        while (valid && n < 30) begin
            tick(1);
            n++;
        end
        ready = 1'b0;
        check_eq("drain_valid", 32'(valid), 32'd0);
        check_eq("drain_data", 32'(data), 32'd0);
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        check_eq("rst_data", 32'(data), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_start", 32'(start), 32'd0);
        check_eq("rst_led", 32'(LED), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Single key, start pulse length
        start_hi = 0;
        press(4'd5, 8'h35, 1'b1);
        check_eq("t1_count", 32'(count), 32'd1);
        check_eq("t1_valid", 32'(valid), 32'd1);
        check_eq("t1_data", 32'(data), 32'h35);
        check_eq("t1_led", 32'(LED), 32'h35);
        check_eq("t1_start_cycles", 32'(start_hi), 32'd4);
        drain();

        // Bouncy press yields one byte
        num = 4'd12;
        PB_state = 1'b1; tick(2);
        PB_state = 1'b0; tick(2);
        PB_state = 1'b1;
        exp_q.push_back(8'h23);
        tick(20);
        PB_state = 1'b0; tick(12);
        check_eq("t2_count", 32'(count), 32'd1);
        drain();

        // Fill, overflow, clear
        press(4'd1, 8'h31, 1'b1);
        press(4'd2, 8'h32, 1'b1);
        press(4'd3, 8'h33, 1'b1);
        press(4'd4, 8'h34, 1'b1);
        press(4'd5, 8'h35, 1'b0);
        check_eq("t3_count", 32'(count), 32'd4);
        check_eq("t3_ovf", 32'(overflow), 32'd1);
        check_eq("t3_led", 32'(LED), 32'h34);
        check_eq("t3_head", 32'(data), 32'h31);
        clr_ovf = 1'b1; tick(1);
        clr_ovf = 1'b0;
        check_eq("t3_ovf_clr", 32'(overflow), 32'd0);

        // Push into a full FIFO on the same edge as a pop
        num = 4'd9;
        PB_state = 1'b1;
        exp_q.push_back(8'h39);
        tick(7);
        ready = 1'b1;
        tick(1);
        check_eq("t4_count_same", 32'(count), 32'd4);
        check_eq("t4_ovf", 32'(overflow), 32'd0);
        check_eq("t4_led", 32'(LED), 32'h39);
        tick(6);
        PB_state = 1'b0;
        tick(12);
        drain();

        // No-key code is never queued
        start_hi = 0;
        press(4'd11, 8'h00, 1'b0);
        check_eq("t5_count", 32'(count), 32'd0);
        check_eq("t5_start", 32'(start_hi), 32'd0);
        check_eq("t5_led", 32'(LED), 32'h39);

        // Reset mid-operation
        press(4'd1, 8'h31, 1'b1);
        press(4'd2, 8'h32, 1'b1);
        num = 4'd3;
        PB_state = 1'b1;
        tick(8);
        check_eq("t6_count_pre", 32'(count), 32'd3);
        check_eq("t6_start_pre", 32'(start), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("t6_count", 32'(count), 32'd0);
        check_eq("t6_valid", 32'(valid), 32'd0);
        check_eq("t6_start", 32'(start), 32'd0);
        check_eq("t6_led", 32'(LED), 32'd0);
        check_eq("t6_data", 32'(data), 32'd0);
        exp_q.delete();
        PB_state = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        check_eq("t6_no_spurious", 32'(count), 32'd0);
        press(4'd7, 8'h37, 1'b1);
        check_eq("t6_fresh_press", 32'(count), 32'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
